// File: rtl/wb_xbar_nxn.sv
// N-initiator x M-target classic Wishbone crossbar: per-target address decode,
// round-robin arbitration locked for the length of CYC, and ERR for unmapped accesses.
module wb_xbar_nxn #(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned N_INITIATORS  = 2,
  parameter int unsigned N_TARGETS     = 4,
  parameter logic [N_TARGETS*WB_ADDR_WIDTH-1:0] T_ADR_MASK = {N_TARGETS{32'hFF00_0000}},
  parameter logic [N_TARGETS*WB_ADDR_WIDTH-1:0] T_ADR      = '0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [N_INITIATORS*WB_ADDR_WIDTH-1:0]     adr,
  input  logic [N_INITIATORS*WB_DATA_WIDTH-1:0]     dat_w,
  output logic [N_INITIATORS*WB_DATA_WIDTH-1:0]     dat_r,
  input  logic [N_INITIATORS-1:0]                   cyc,
  input  logic [N_INITIATORS-1:0]                   stb,
  input  logic [N_INITIATORS-1:0]                   we,
  input  logic [N_INITIATORS*WB_DATA_WIDTH/8-1:0]   sel,
  output logic [N_INITIATORS-1:0]                   ack,
  output logic [N_INITIATORS-1:0]                   err,
  output logic [N_TARGETS*WB_ADDR_WIDTH-1:0]        tadr,
  output logic [N_TARGETS*WB_DATA_WIDTH-1:0]        tdat_w,
  output logic [N_TARGETS*WB_DATA_WIDTH/8-1:0]      tsel,
  output logic [N_TARGETS-1:0]                      tcyc,
  output logic [N_TARGETS-1:0]                      tstb,
  output logic [N_TARGETS-1:0]                      twe,
  input  logic [N_TARGETS*WB_DATA_WIDTH-1:0]        tdat_r,
  input  logic [N_TARGETS-1:0]                      tack,
  input  logic [N_TARGETS-1:0]                      terr
);

  localparam int AW = int'(WB_ADDR_WIDTH);
  localparam int DW = int'(WB_DATA_WIDTH);
  localparam int SW = DW / 8;
  localparam int NI = int'(N_INITIATORS);
  localparam int NT = int'(N_TARGETS);
  localparam int IW = (NI > 1) ? $clog2(NI) : 1;

  logic [NI-1:0][NT-1:0] dec;      // one-hot, lowest matching target wins
  logic [NI-1:0]         any_hit;
  logic [NT-1:0][NI-1:0] req;

  logic [NT-1:0]         owned_q, owned_d;
  logic [NT-1:0][IW-1:0] owner_q, owner_d;
  logic [NT-1:0][IW-1:0] ptr_q, ptr_d;
  logic [NI-1:0]         uerr_q, uerr_d;

  always_comb begin
    logic found;
    dec     = '0;
    any_hit = '0;
    req     = '0;
    for (int i = 0; i < NI; i++) begin
      found = 1'b0;
      for (int t = 0; t < NT; t++) begin
        if (!found && ((adr[i*AW +: AW] & T_ADR_MASK[t*AW +: AW]) == T_ADR[t*AW +: AW])) begin
          dec[i][t] = 1'b1;
          found     = 1'b1;
        end
      end
      any_hit[i] = found;
      for (int t = 0; t < NT; t++) begin
        req[t][i] = cyc[i] & stb[i] & dec[i][t];
      end
    end
  end

  // Arbitration: grant only from IDLE, so release and re-grant take separate cycles.
  always_comb begin
    logic found;
    int   idx;
    int   own;
    owned_d = owned_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    own     = 0;
    for (int t = 0; t < NT; t++) begin
      if (!owned_q[t]) begin
        found = 1'b0;
        for (int k = 0; k < NI; k++) begin
          idx = (int'(ptr_q[t]) + k) % NI;
          if (!found && req[t][idx]) begin
            found      = 1'b1;
            owned_d[t] = 1'b1;
            owner_d[t] = IW'(idx);
          end
        end
      end else begin
        own = int'(owner_q[t]);
        if (!cyc[own] || (stb[own] && !dec[own][t])) begin
          owned_d[t] = 1'b0;
          ptr_d[t]   = IW'((own + 1) % NI);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      uerr_d[i] = cyc[i] & stb[i] & ~any_hit[i] & ~uerr_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owned_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      uerr_q  <= '0;
    end else begin
      owned_q <= owned_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      uerr_q  <= uerr_d;
    end
  end

  // Strobe and responses are qualified by the owner still addressing this target, so the
  // cycle in which an owner moves on never leaks a strobe or reply through the old target.
  always_comb begin
    int own;
    own    = 0;
    tadr   = '0;
    tdat_w = '0;
    tsel   = '0;
    tcyc   = '0;
    tstb   = '0;
    twe    = '0;
    ack    = '0;
    err    = '0;
    dat_r  = '0;
    for (int t = 0; t < NT; t++) begin
      if (owned_q[t]) begin
        own                = int'(owner_q[t]);
        tcyc[t]            = cyc[own];
        tstb[t]            = stb[own] & dec[own][t];
        twe[t]             = we[own];
        tadr[t*AW +: AW]   = adr[own*AW +: AW];
        tdat_w[t*DW +: DW] = dat_w[own*DW +: DW];
        tsel[t*SW +: SW]   = sel[own*SW +: SW];
        if (dec[own][t]) begin
          ack[own]             = ack[own] | tack[t];
          err[own]             = err[own] | terr[t];
          dat_r[own*DW +: DW]  = dat_r[own*DW +: DW] | tdat_r[t*DW +: DW];
        end
      end
    end
    err = err | uerr_q;
  end

endmodule

// File: tb/tb_wb_xbar_nxn.sv
// Directed bench for wb_xbar_nxn: targets 0..3 at 0x40/0x20/0x30/0x10 << 24,
// with a combinational zero-wait responder per target.
module tb_wb_xbar_nxn;

  logic         clk;
  logic         rst;
  logic [63:0]  adr;
  logic [63:0]  dat_w;
  logic [63:0]  dat_r;
  logic [1:0]   cyc, stb, we;
  logic [7:0]   sel;
  logic [1:0]   ack, err;
  logic [127:0] tadr;
  logic [127:0] tdat_w;
  logic [15:0]  tsel;
  logic [3:0]   tcyc, tstb, twe;
  logic [127:0] tdat_r;
  logic [3:0]   tack, terr;
  logic [3:0]   tack_en, terr_en;

  int checks = 0;
  int errors = 0;

  wb_xbar_nxn #(
    .WB_ADDR_WIDTH(32),
    .WB_DATA_WIDTH(32),
    .N_INITIATORS (2),
    .N_TARGETS    (4),
    .T_ADR_MASK   ({4{32'hFF00_0000}}),
    .T_ADR        ({32'h1000_0000, 32'h3000_0000, 32'h2000_0000, 32'h4000_0000})
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .adr   (adr),
    .dat_w (dat_w),
    .dat_r (dat_r),
    .cyc   (cyc),
    .stb   (stb),
    .we    (we),
    .sel   (sel),
    .ack   (ack),
    .err   (err),
    .tadr  (tadr),
    .tdat_w(tdat_w),
    .tsel  (tsel),
    .tcyc  (tcyc),
    .tstb  (tstb),
    .twe   (twe),
    .tdat_r(tdat_r),
    .tack  (tack),
    .terr  (terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    tack = tcyc & tstb & tack_en;
    terr = tcyc & tstb & terr_en;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int i, input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s);
    adr[i*32 +: 32]   = a;
    dat_w[i*32 +: 32] = d;
    we[i]             = w;
    sel[i*4 +: 4]     = s;
    cyc[i]            = 1'b1;
    stb[i]            = 1'b1;
  endtask

  task automatic idle(input int i);
    cyc[i] = 1'b0;
    stb[i] = 1'b0;
    we[i]  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    adr = '0; dat_w = '0; cyc = '0; stb = '0; we = '0; sel = '0;
    tdat_r = '0; tack_en = '0; terr_en = '0;
    tick();
    check("rst_tcyc", tcyc, 4'b0000);
    check("rst_ack", ack, 2'b00);
    check("rst_err", err, 2'b00);
    check("rst_tadr", tadr, 128'h0);
    #3 rst = 1'b0;
    tick();

    // 1: init0 write to target 3
    req(0, 32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 4'h5);
    #1 check("t1_latency_tcyc", tcyc, 4'b0000);
    tick();
    check("t1_tcyc", tcyc, 4'b1000);
    check("t1_tstb", tstb, 4'b1000);
    check("t1_twe", twe, 4'b1000);
    check("t1_tadr", tadr[127:96], 32'h1000_0004);
    check("t1_tdat_w", tdat_w[127:96], 32'hDEAD_BEEF);
    check("t1_tsel", tsel[15:12], 4'h5);
    check("t1_no_ack", ack, 2'b00);
    tack_en = 4'b1000;
    #1 check("t1_ack", ack, 2'b01);
    idle(0); tack_en = '0;
    tick();
    check("t1_released", tcyc, 4'b0000);

    // 2: init1 read from target 0, then an error passed through
    tdat_r[31:0] = 32'h1234_5678;
    tack_en = 4'b0001;
    req(1, 32'h4000_0010, 1'b0, 32'h0, 4'hF);
    #1 check("t2_wait_ack", ack, 2'b00);
    tick();
    check("t2_tcyc", tcyc, 4'b0001);
    check("t2_twe", twe, 4'b0000);
    check("t2_ack", ack, 2'b10);
    check("t2_dat_r1", dat_r[63:32], 32'h1234_5678);
    check("t2_dat_r0", dat_r[31:0], 32'h0);
    tack_en = '0; terr_en = 4'b0001;
    #1 check("t2_terr", err, 2'b10);
    check("t2_terr_noack", ack, 2'b00);
    idle(1); terr_en = '0;
    tick();
    check("t2_released", tcyc, 4'b0000);

    // 3a: both on target 1, init0 first, init1 after init0 drops
    req(0, 32'h2000_0000, 1'b1, 32'hAAAA_0000, 4'hF);
    req(1, 32'h2000_0000, 1'b1, 32'hBBBB_0000, 4'hF);
    tick();
    check("t3_first_owner", tdat_w[63:32], 32'hAAAA_0000);
    check("t3_wait_noack", ack, 2'b00);
    tack_en = 4'b0010;
    #1 check("t3_ack0", ack, 2'b01);
    idle(0); tack_en = '0;
    tick();
    check("t3_gap", tcyc, 4'b0000);
    tick();
    check("t3_second_tcyc", tcyc, 4'b0010);
    check("t3_second_owner", tdat_w[63:32], 32'hBBBB_0000);
    tack_en = 4'b0010;
    #1 check("t3_ack1", ack, 2'b10);
    idle(1); tack_en = '0;
    tick();

    // 3b: target 3 pointer moved past init0 in step 1, so init1 wins now
    req(0, 32'h1000_0000, 1'b1, 32'hAAAA_0000, 4'hF);
    req(1, 32'h1000_0000, 1'b1, 32'hBBBB_0000, 4'hF);
    tick();
    check("t3b_rr_owner", tdat_w[127:96], 32'hBBBB_0000);
    idle(1);
    tick();
    tick();
    check("t3b_next_owner", tdat_w[127:96], 32'hAAAA_0000);
    idle(0);
    tick();

    // 4: parallel accesses to targets 3 and 2
    req(0, 32'h1000_0000, 1'b1, 32'h1111_1111, 4'hF);
    req(1, 32'h3000_0000, 1'b1, 32'h2222_2222, 4'hF);
    tick();
    check("t4_tcyc", tcyc, 4'b1100);
    check("t4_tdat_w3", tdat_w[127:96], 32'h1111_1111);
    check("t4_tdat_w2", tdat_w[95:64], 32'h2222_2222);
    tack_en = 4'b1100;
    #1 check("t4_ack", ack, 2'b11);
    idle(0); idle(1); tack_en = '0;
    tick();
    check("t4_released", tcyc, 4'b0000);

    // 5: unmapped access
    req(0, 32'h5000_0000, 1'b0, 32'h0, 4'hF);
    #1 check("t5_err_early", err, 2'b00);
    tick();
    check("t5_err_pulse", err, 2'b01);
    check("t5_no_tcyc", tcyc, 4'b0000);
    tick();
    check("t5_err_gap", err, 2'b00);
    tick();
    check("t5_err_repulse", err, 2'b01);
    idle(0);
    tick();
    check("t5_err_clear", err, 2'b00);

    // 6: reset in the middle of an owned transfer
    req(1, 32'h2000_0008, 1'b1, 32'hCAFE_F00D, 4'h3);
    tack_en = 4'b0010;
    tick();
    check("t6_tcyc", tcyc, 4'b0010);
    check("t6_ack", ack, 2'b10);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_tcyc", tcyc, 4'b0000);
    check("t6_rst_tstb", tstb, 4'b0000);
    check("t6_rst_ack", ack, 2'b00);
    check("t6_rst_tadr", tadr, 128'h0);
    tick();
    #3 rst = 1'b0;
    #1 check("t6_post_rst_latency", tcyc, 4'b0000);
    tick();
    check("t6_regrant_tcyc", tcyc, 4'b0010);
    check("t6_regrant_data", tdat_w[63:32], 32'hCAFE_F00D);
    check("t6_regrant_ack", ack, 2'b10);
    idle(1); tack_en = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
